game_turn_ctrl: RTL and testbench

GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

---
 rtl/game_pkg.sv | 19 +
 rtl/game_turn_ctrl_if.sv | 40 ++++
 rtl/game_turn_ctrl_next_alive_sel.sv | 34 +++
 rtl/game_turn_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game controller, display and UART
// blocks.
//   state_t     : 3-bit controller state (IDLE/TURN/CHECK/GAME_OVER)
//   STATE_W     : width of the state encoding as seen on state_o
//   MIN/MAX_PLAYERS : supported player-count range
package game_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned MIN_PLAYERS = 2;
  localparam int unsigned MAX_PLAYERS = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    TURN      = 3'd1,
    CHECK     = 3'd2,
    GAME_OVER = 3'd3
  } state_t;

endpackage

// File: rtl/game_turn_ctrl_if.sv
// game_turn_ctrl_if -- groups the player inputs and the status outputs of
// game_turn_ctrl.
//   master modport : the player/console side (drives start_req, turn_done, hp)
//   slave modport  : the controller side (drives turn/winner/round status)
// clk and rst are not part of the bundle.
interface game_turn_ctrl_if
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned HP_W        = 10,
  parameter int unsigned ROUND_W     = 8
);
  localparam int unsigned PID_W = $clog2(NUM_PLAYERS);

  logic [NUM_PLAYERS-1:0]      start_req;
  logic [NUM_PLAYERS-1:0]      turn_done;
  logic [NUM_PLAYERS*HP_W-1:0] hp;
  logic [NUM_PLAYERS-1:0]      turn_onehot;
  logic [PID_W-1:0]            active_player;
  logic [STATE_W-1:0]          state_o;
  logic                        next_turn;
  logic [PID_W-1:0]            winner;
  logic                        winner_valid;
  logic                        draw;
  logic [ROUND_W-1:0]          round_cnt;
  logic                        timeout_pulse;

  modport master (
    output start_req, turn_done, hp,
    input  turn_onehot, active_player, state_o, next_turn, winner,
           winner_valid, draw, round_cnt, timeout_pulse
  );

  modport slave (
    input  start_req, turn_done, hp,
    output turn_onehot, active_player, state_o, next_turn, winner,
           winner_valid, draw, round_cnt, timeout_pulse
  );

endinterface

// File: rtl/game_turn_ctrl_next_alive_sel.sv
// next_alive_sel -- combinational round-robin search for the first alive
// player strictly after cur_idx, wrapping around.
//   alive    : per-player alive flags
//   cur_idx  : index the search starts after
//   next_idx : selected player (cur_idx itself if it is the only one alive)
//   wrap     : selected index <= cur_idx, i.e. the search wrapped
module next_alive_sel #(
  parameter  int unsigned NUM_PLAYERS = 2,
  localparam int unsigned PID_W       = $clog2(NUM_PLAYERS)
) (
  input  logic [NUM_PLAYERS-1:0] alive,
  input  logic [PID_W-1:0]       cur_idx,
  output logic [PID_W-1:0]       next_idx,
  output logic                   wrap
);

  always_comb begin
    logic        found;
    int unsigned cur_u;
    logic [PID_W-1:0] idx;
    found    = 1'b0;
    next_idx = cur_idx;
    cur_u    = 32'(cur_idx);
    for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
      idx = PID_W'((cur_u + k) % NUM_PLAYERS);
      if (!found && alive[idx]) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
    wrap = (next_idx <= cur_idx);
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl -- turn sequencer for a 2..4 player game.
//   clk, rst        : clock, synchronous active-high reset
//   start_req       : per-player start press (lowest index starts the game)
//   turn_done       : per-player end-of-turn pulse (only the active one counts)
//   hp              : packed HP, player i at [i*HP_W +: HP_W]; nonzero = alive
//   turn_onehot     : active player one-hot (zero outside a running game)
//   active_player   : active player index
//   state_o         : current state encoding (game_pkg::state_t)
//   next_turn       : high while in TURN
//   winner/winner_valid/draw : game result, held in GAME_OVER
//   round_cnt       : completed rounds, saturating
//   timeout_pulse   : one-cycle pulse when a turn is forfeited on time
// Optional feature: define GAME_TURN_TIMEOUT_EN to enable the per-turn time
// limit of TIMEOUT_CYCLES clocks; otherwise timeout_pulse stays 0.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS    = 2,
  parameter  int unsigned HP_W           = 10,
  parameter  int unsigned ROUND_W        = 8,
  parameter  int unsigned TIMEOUT_CYCLES = 100_000_000,
  localparam int unsigned PID_W          = $clog2(NUM_PLAYERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PLAYERS-1:0]      start_req,
  input  logic [NUM_PLAYERS-1:0]      turn_done,
  input  logic [NUM_PLAYERS*HP_W-1:0] hp,
  output logic [NUM_PLAYERS-1:0]      turn_onehot,
  output logic [PID_W-1:0]            active_player,
  output logic [STATE_W-1:0]          state_o,
  output logic                        next_turn,
  output logic [PID_W-1:0]            winner,
  output logic                        winner_valid,
  output logic                        draw,
  output logic [ROUND_W-1:0]          round_cnt,
  output logic                        timeout_pulse
);

  if (NUM_PLAYERS < MIN_PLAYERS || NUM_PLAYERS > MAX_PLAYERS || TIMEOUT_CYCLES == 0) begin : g_cfg_err
    $error("game_turn_ctrl: unsupported NUM_PLAYERS or TIMEOUT_CYCLES");
  end

  localparam logic [NUM_PLAYERS-1:0] ONE = NUM_PLAYERS'(1);

  state_t                 state_q, state_d;
  logic [PID_W-1:0]       active_q, active_d;
  logic [NUM_PLAYERS-1:0] onehot_q, onehot_d;
  logic                   next_turn_q, next_turn_d;
  logic [PID_W-1:0]       winner_q, winner_d;
  logic                   winner_valid_q, winner_valid_d;
  logic                   draw_q, draw_d;
  logic [ROUND_W-1:0]     round_q, round_d;
  logic                   timeout_pulse_q, timeout_pulse_d;

  logic [NUM_PLAYERS-1:0] alive;
  int unsigned            n_alive;
  logic [PID_W-1:0]       survivor;
  logic [PID_W-1:0]       first_start;
  logic [PID_W-1:0]       sel_idx;
  logic                   sel_wrap;
  logic                   tmo_hit;

  // alive flags, alive count, and the (last) alive index used as the winner
  always_comb begin
    n_alive  = 0;
    survivor = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      alive[i] = |hp[i*HP_W +: HP_W];
      if (alive[i]) begin
        n_alive  = n_alive + 1;
        survivor = PID_W'(i);
      end
    end
  end

  always_comb begin
    logic found;
    found       = 1'b0;
    first_start = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (start_req[i] && !found) begin
        found       = 1'b1;
        first_start = PID_W'(i);
      end
    end
  end

  next_alive_sel #(.NUM_PLAYERS(NUM_PLAYERS)) u_next_alive_sel (
    .alive    (alive),
    .cur_idx  (active_q),
    .next_idx (sel_idx),
    .wrap     (sel_wrap)
  );

`ifdef GAME_TURN_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // TURN is only ever entered from another state, so clearing whenever we
  // are outside TURN is the same as clearing on every entry to TURN.
  always_comb begin
    tmo_cnt_d = (state_q == TURN) ? tmo_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (state_q == TURN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    onehot_d        = onehot_q;
    next_turn_d     = next_turn_q;
    winner_d        = winner_q;
    winner_valid_d  = winner_valid_q;
    draw_d          = draw_q;
    round_d         = round_q;
    timeout_pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|start_req) begin
          state_d     = TURN;
          active_d    = first_start;
          onehot_d    = ONE << first_start;
          round_d     = '0;
          next_turn_d = 1'b1;
        end
      end

      TURN, CHECK: begin
        if (n_alive <= 1) begin
          state_d        = GAME_OVER;
          onehot_d       = '0;
          next_turn_d    = 1'b0;
          winner_valid_d = (n_alive == 1);
          draw_d         = (n_alive == 0);
          winner_d       = (n_alive == 1) ? survivor : '0;
        end else if (state_q == TURN) begin
          // a dead active player is skipped through CHECK like a finished turn
          if (turn_done[active_q] || !alive[active_q] || tmo_hit) begin
            state_d         = CHECK;
            next_turn_d     = 1'b0;
            timeout_pulse_d = tmo_hit && !turn_done[active_q];
          end
        end else begin
          state_d     = TURN;
          active_d    = sel_idx;
          onehot_d    = ONE << sel_idx;
          next_turn_d = 1'b1;
          if (sel_wrap && (round_q != '1)) round_d = round_q + 1'b1;
        end
      end

      GAME_OVER: begin
        if (|start_req) begin
          state_d        = IDLE;
          winner_valid_d = 1'b0;
          draw_d         = 1'b0;
        end
      end

      default: begin
        state_d        = IDLE;
        active_d       = '0;
        onehot_d       = '0;
        next_turn_d    = 1'b0;
        winner_d       = '0;
        winner_valid_d = 1'b0;
        draw_d         = 1'b0;
        round_d        = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      active_q        <= '0;
      onehot_q        <= '0;
      next_turn_q     <= 1'b0;
      winner_q        <= '0;
      winner_valid_q  <= 1'b0;
      draw_q          <= 1'b0;
      round_q         <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      onehot_q        <= onehot_d;
      next_turn_q     <= next_turn_d;
      winner_q        <= winner_d;
      winner_valid_q  <= winner_valid_d;
      draw_q          <= draw_d;
      round_q         <= round_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign state_o       = state_q;
  assign active_player = active_q;
  assign turn_onehot   = onehot_q;
  assign next_turn     = next_turn_q;
  assign winner        = winner_q;
  assign winner_valid  = winner_valid_q;
  assign draw          = draw_q;
  assign round_cnt     = round_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
module tb_game_turn_ctrl;

  localparam int unsigned NP  = 3;
  localparam int unsigned HW  = 10;
  localparam int unsigned RW  = 3;
  localparam int unsigned TMO = 16;
`ifdef GAME_TURN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_turn_ctrl_if #(.NUM_PLAYERS(NP), .HP_W(HW), .ROUND_W(RW)) bus ();

  game_turn_ctrl #(
    .NUM_PLAYERS(NP), .HP_W(HW), .ROUND_W(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_req     (bus.start_req),
    .turn_done     (bus.turn_done),
    .hp            (bus.hp),
    .turn_onehot   (bus.turn_onehot),
    .active_player (bus.active_player),
    .state_o       (bus.state_o),
    .next_turn     (bus.next_turn),
    .winner        (bus.winner),
    .winner_valid  (bus.winner_valid),
    .draw          (bus.draw),
    .round_cnt     (bus.round_cnt),
    .timeout_pulse (bus.timeout_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0=idle 1=turn 2=check 3=game over
  int m_st, m_act, m_win, m_round, m_age;
  bit m_nt, m_wv, m_draw, m_tp;

  function automatic bit alive_of(int p);
    return bus.hp[p*HW +: HW] != '0;
  endfunction

  task automatic model_step();
    int nalive, last, nxt;
    bit done, expired;
    nalive = 0;
    last   = 0;
    for (int i = 0; i < NP; i++) if (alive_of(i)) begin nalive++; last = i; end
    m_tp = 0;
    if (rst) begin
      m_st = 0; m_act = 0; m_nt = 0; m_win = 0; m_wv = 0; m_draw = 0;
      m_round = 0; m_age = 0;
      return;
    end
    case (m_st)
      0: if (bus.start_req != '0) begin
        for (int i = NP - 1; i >= 0; i--) if (bus.start_req[i]) m_act = i;
        m_st = 1; m_nt = 1; m_round = 0; m_age = 0;
      end
      1, 2: begin
        if (nalive <= 1) begin
          m_st = 3; m_nt = 0;
          m_wv = (nalive == 1); m_draw = (nalive == 0);
          m_win = (nalive == 1) ? last : 0;
        end else if (m_st == 1) begin
          done    = bus.turn_done[m_act];
          expired = TMO_EN && (m_age == TMO - 1);
          if (done || !alive_of(m_act) || expired) begin
            m_st = 2; m_nt = 0; m_tp = expired && !done;
          end else m_age++;
        end else begin
          nxt = m_act;
          for (int k = NP; k >= 1; k--) if (alive_of((m_act + k) % NP)) nxt = (m_act + k) % NP;
          if (nxt <= m_act && m_round < (1 << RW) - 1) m_round++;
          m_act = nxt; m_st = 1; m_nt = 1; m_age = 0;
        end
      end
      default: if (bus.start_req != '0) begin m_st = 0; m_wv = 0; m_draw = 0; end
    endcase
  endtask

  task automatic compare_all();
    logic [NP-1:0] exp_oh;
    exp_oh = '0;
    if (m_st == 1 || m_st == 2) exp_oh[m_act] = 1'b1;
    chk("state_o",       32'(bus.state_o),       m_st);
    chk("active_player", 32'(bus.active_player), m_act);
    chk("turn_onehot",   32'(bus.turn_onehot),   32'(exp_oh));
    chk("next_turn",     32'(bus.next_turn),     32'(m_nt));
    chk("winner",        32'(bus.winner),        m_win);
    chk("winner_valid",  32'(bus.winner_valid),  32'(m_wv));
    chk("draw",          32'(bus.draw),          32'(m_draw));
    chk("round_cnt",     32'(bus.round_cnt),     m_round);
    chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_tp));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_hp(input int p, input int v);
    bus.hp[p*HW +: HW] = HW'(v);
  endtask

  task automatic done_pulse(input int p);
    bus.turn_done = '0;
    bus.turn_done[p] = 1'b1;
    tick();
    bus.turn_done = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pulses;

  initial begin
    bus.start_req = '0;
    bus.turn_done = '0;
    for (int p = 0; p < NP; p++) set_hp(p, 50);
    m_st = 0; m_act = 0; m_win = 0; m_round = 0; m_age = 0;
    m_nt = 0; m_wv = 0; m_draw = 0; m_tp = 0;

    rst = 1'b1; tick(); tick();
    chk("reset_state", 32'(bus.state_o), 0);
    rst = 1'b0;

    // start: lowest requesting player wins
    bus.start_req = 3'b110; tick(); bus.start_req = '0;
    chk("start_ap", 32'(bus.active_player), 1);
    chk("start_oh", 32'(bus.turn_onehot), 32'b010);
    chk("start_st", 32'(bus.state_o), 1);

    // rotation 1 -> 2 -> 0 with wrap counting
    done_pulse(1); chk("rot_ap2", 32'(bus.active_player), 2);
    done_pulse(2); chk("rot_ap0", 32'(bus.active_player), 0);
    chk("rot_round1", 32'(bus.round_cnt), 1);
    bus.turn_done = 3'b100; tick(); bus.turn_done = '0;
    chk("foreign_done_st", 32'(bus.state_o), 1);
    chk("foreign_done_ap", 32'(bus.active_player), 0);
    done_pulse(0); chk("rot_ap1", 32'(bus.active_player), 1);

    // round counter saturation
    for (int r = 0; r < 7; r++) begin done_pulse(1); done_pulse(2); done_pulse(0); end
    chk("round_sat", 32'(bus.round_cnt), 7);
    done_pulse(1); done_pulse(2);

    // skip a dead player, then single survivor
    set_hp(1, 0); tick();
    done_pulse(0); chk("skip_dead_ap", 32'(bus.active_player), 2);
    set_hp(2, 0); tick();
    chk("win_st", 32'(bus.state_o), 3);
    chk("win_idx", 32'(bus.winner), 0);
    chk("win_valid", 32'(bus.winner_valid), 1);
    bus.start_req = 3'b001; tick(); bus.start_req = '0;
    chk("over_to_idle_wv", 32'(bus.winner_valid), 0);

    // draw beats a simultaneous turn_done
    set_hp(0, 50); set_hp(1, 50); set_hp(2, 0);
    bus.start_req = 3'b001; tick(); bus.start_req = '0;
    set_hp(0, 0); set_hp(1, 0); bus.turn_done = 3'b001; tick(); bus.turn_done = '0;
    chk("draw_st", 32'(bus.state_o), 3);
    chk("draw_flag", 32'(bus.draw), 1);
    chk("draw_wv", 32'(bus.winner_valid), 0);
    bus.start_req = 3'b001; tick(); bus.start_req = '0;

    // turn time limit
    for (int p = 0; p < NP; p++) set_hp(p, 50);
    bus.start_req = 3'b001; tick(); bus.start_req = '0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin tick(); pulses += int'(bus.timeout_pulse); end
`ifdef GAME_TURN_TIMEOUT_EN
    chk("tmo_pulse_cnt", 32'(pulses), 1);
    chk("tmo_st", 32'(bus.state_o), 2);
    tick(); chk("tmo_next_ap", 32'(bus.active_player), 1);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin tick(); pulses += int'(bus.timeout_pulse); end
    bus.turn_done = 3'b010; tick(); bus.turn_done = '0;
    pulses += int'(bus.timeout_pulse);
    chk("tmo_done_wins", 32'(pulses), 0);
    chk("tmo_done_st", 32'(bus.state_o), 2);
`else
    chk("no_tmo_pulse", 32'(pulses), 0);
    chk("no_tmo_st", 32'(bus.state_o), 1);
`endif
    tick();

    // reset mid-game, then a fresh game
    done_pulse(int'(bus.active_player));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_st", 32'(bus.state_o), 0);
    chk("rst_oh", 32'(bus.turn_onehot), 0);
    bus.start_req = 3'b100; tick(); bus.start_req = '0;
    chk("fresh_ap", 32'(bus.active_player), 2);
    chk("fresh_round", 32'(bus.round_cnt), 0);

    // randomized traffic
    for (int c = 0; c < 900; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.start_req = ($urandom_range(0, 7) == 0) ? NP'($urandom_range(1, 7)) : '0;
      bus.turn_done = NP'($urandom_range(0, 7));
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 29) == 0)
          set_hp(p, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 1023)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
